// File: rtl/vec_pkg.sv
// Shared FSM state type and width helper for the vec_acc vector accumulator.
package vec_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    OUT   = 2'd2
  } state_e;

  // A beat sum of vector_len elements of bw_i bits can never overflow this width.
  function automatic int sum_width(input int bw_i, input int vector_len);
    return bw_i + $clog2(vector_len);
  endfunction

endpackage

// File: rtl/vec_sum_tree.sv
// Combinational balanced adder tree reducing one beat of signed elements to a single sum.
module vec_sum_tree
  import vec_pkg::*;
#(
  parameter int BW_I       = 32,
  parameter int VECTOR_LEN = 13,
  parameter int BW_S       = sum_width(BW_I, VECTOR_LEN)
) (
  input  logic        [VECTOR_LEN*BW_I-1:0] data_i,
  output logic signed [BW_S-1:0]            sum_o
);

  localparam int LEVELS = $clog2(VECTOR_LEN);
  localparam int LEAVES = 1 << LEVELS;

  // Level 0 holds the sign-extended elements padded with zeros to a power of two.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic signed [BW_S-1:0] s [LEAVES >> l];
    for (genvar k = 0; k < (LEAVES >> l); k++) begin : g_node
      if (l == 0) begin : g_leaf
        if (k < VECTOR_LEN) begin : g_elem
          assign s[k] = BW_S'($signed(data_i[k*BW_I +: BW_I]));
        end else begin : g_pad
          assign s[k] = '0;
        end
      end else begin : g_add
        assign s[k] = g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
      end
    end
  end

  assign sum_o = g_lvl[LEVELS].s[0];

endmodule

// File: rtl/vec_acc.sv
// Two-stage frame accumulator: registered beat sum, then BW_O accumulator with sticky overflow.
// Define VEC_ACC_SAT_EN to clamp each accumulator update instead of wrapping.
module vec_acc
  import vec_pkg::*;
#(
  parameter int BW_I       = 32,
  parameter int BW_O       = 32,
  parameter int VECTOR_LEN = 13,
  parameter int BW_CNT     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [VECTOR_LEN*BW_I-1:0] data_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  output logic                       ready_o,
  output logic [BW_O-1:0]            data_o,
  output logic [BW_CNT-1:0]          beat_cnt_o,
  output logic                       overflow_o,
  output logic                       valid_o,
  input  logic                       ready_i
);

  localparam int BW_S = sum_width(BW_I, VECTOR_LEN);
  localparam int BW_X = ((BW_O > BW_S) ? BW_O : BW_S) + 1;

`ifdef VEC_ACC_SAT_EN
  localparam logic signed [BW_O-1:0] SAT_MAX = {1'b0, {(BW_O-1){1'b1}}};
  localparam logic signed [BW_O-1:0] SAT_MIN = {1'b1, {(BW_O-1){1'b0}}};
`endif

  state_e                 state_q, state_d;
  logic signed [BW_S-1:0] sum_c, s1_q, s1_d;
  logic                   s1_vld_q, s1_vld_d;
  logic signed [BW_O-1:0] acc_q, acc_d;
  logic [BW_CNT-1:0]      cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic signed [BW_X-1:0] exact;
  logic signed [BW_O-1:0] wrapped;
  logic                   ovf_now, accept, out_done;

  vec_sum_tree #(
    .BW_I      (BW_I),
    .VECTOR_LEN(VECTOR_LEN),
    .BW_S      (BW_S)
  ) u_sum_tree (
    .data_i(data_i),
    .sum_o (sum_c)
  );

  assign ready_o  = (state_q == ACC);
  assign valid_o  = (state_q == OUT);
  assign accept   = valid_i && ready_o;
  assign out_done = valid_o && ready_i;

  // Exact sum is one bit wider than either operand, so range checks are lossless.
  assign exact   = BW_X'(acc_q) + BW_X'(s1_q);
  assign wrapped = exact[BW_O-1:0];
  assign ovf_now = s1_vld_q && (exact != BW_X'(wrapped));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (valid_i && last_i) state_d = FLUSH;
      FLUSH:   state_d = OUT;
      OUT:     if (ready_i) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    s1_d     = s1_q;
    s1_vld_d = accept;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (accept) begin
      s1_d = sum_c;
      if (cnt_q != '1) cnt_d = cnt_q + BW_CNT'(1);
    end
    if (s1_vld_q) begin
`ifdef VEC_ACC_SAT_EN
      if (ovf_now) acc_d = exact[BW_X-1] ? SAT_MIN : SAT_MAX;
      else         acc_d = wrapped;
`else
      acc_d = wrapped;
`endif
      ovf_d = ovf_q | ovf_now;
    end
    // The pipeline is empty in OUT, so clearing cannot drop a pending beat.
    if (out_done) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ACC;
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign data_o     = acc_q;
  assign beat_cnt_o = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_vec_acc.sv
// Scoreboard bench for vec_acc; a narrow beat counter makes saturation reachable quickly.
module tb_vec_acc;

  localparam int BW_I   = 32;
  localparam int BW_O   = 32;
  localparam int VL     = 13;
  localparam int BW_CNT = 4;
  localparam int W      = VL * BW_I;
  localparam longint MAXV = (longint'(1) << (BW_O - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (BW_O - 1));

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic [W-1:0]      data_i  = '0;
  logic              valid_i = 1'b0;
  logic              last_i  = 1'b0;
  logic              ready_i = 1'b1;
  logic              ready_o, valid_o, overflow_o;
  logic [BW_O-1:0]   data_o;
  logic [BW_CNT-1:0] beat_cnt_o;

  typedef struct {
    logic [BW_O-1:0]   data;
    logic [BW_CNT-1:0] cnt;
    logic              ovf;
  } exp_t;

  exp_t   sbq[$];
  exp_t   e;
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;
  int     checks = 0;
  int     errors = 0;

  vec_acc #(
    .BW_I(BW_I), .BW_O(BW_O), .VECTOR_LEN(VL), .BW_CNT(BW_CNT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_o), .data_o(data_o), .beat_cnt_o(beat_cnt_o), .overflow_o(overflow_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fill(input logic [BW_I-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < VL; i++) r[i*BW_I +: BW_I] = v;
    return r;
  endfunction

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_accept(input logic [W-1:0] d, input bit last);
    longint s = 0;
    longint x;
    exp_t   t;
    for (int i = 0; i < VL; i++) s += longint'($signed(d[i*BW_I +: BW_I]));
    x = m_acc + s;
    if (x > MAXV || x < MINV) begin
      m_ovf = 1'b1;
`ifdef VEC_ACC_SAT_EN
      x = (x > MAXV) ? MAXV : MINV;
`endif
    end
    m_acc = (x <<< (64 - BW_O)) >>> (64 - BW_O);
    if (m_cnt < (1 << BW_CNT) - 1) m_cnt++;
    if (last) begin
      t.data = BW_O'(m_acc);
      t.cnt  = BW_CNT'(m_cnt);
      t.ovf  = m_ovf;
      sbq.push_back(t);
      model_clear();
    end
  endtask

  // Called at a negedge with the DUT in ACC; returns at the negedge after the accepting edge.
  task automatic drive_beat(input logic [W-1:0] d, input bit last);
    data_i  = d;
    valid_i = 1'b1;
    last_i  = last;
    @(posedge clk);
    model_accept(d, last);
    @(negedge clk);
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = '0;
  endtask

  task automatic test_reset();
    data_i  = fill(32'd1);
    valid_i = 1'b1;
    last_i  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready_o, valid_o, data_o, beat_cnt_o, overflow_o} !== {1'b1, 1'b0, {BW_O{1'b0}}, {BW_CNT{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%0d cnt=%0d ovf=%b required rdy=1 vld=0 data=0 cnt=0 ovf=0",
               ready_o, valid_o, data_o, beat_cnt_o, overflow_o);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = '0;
    rst_n   = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid_o, ready_o, beat_cnt_o} !== {1'b0, 1'b1, {BW_CNT{1'b0}}}) begin
      errors++;
      $display("FAIL reset_no_accept: vld=%b rdy=%b cnt=%0d required vld=0 rdy=1 cnt=0", valid_o, ready_o, beat_cnt_o);
    end
  endtask

  task automatic test_single_beat();
    ready_i = 1'b1;
    drive_beat(fill(32'd1), 1'b1);
    checks++;
    if ({valid_o, ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL single_flush: vld=%b rdy=%b required vld=0 rdy=0", valid_o, ready_o);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: vld=%b required 1", valid_o);
    end
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL single_result: queue empty required 1 entry");
    end else begin
      e = sbq.pop_front();
      if ({data_o, beat_cnt_o, overflow_o} !== {e.data, e.cnt, e.ovf}) begin
        errors++;
        $display("FAIL single_result: data=%0d cnt=%0d ovf=%b required data=%0d cnt=%0d ovf=%b",
                 $signed(data_o), beat_cnt_o, overflow_o, $signed(e.data), e.cnt, e.ovf);
      end
    end
    @(negedge clk);
    checks++;
    if ({valid_o, ready_o, data_o, beat_cnt_o, overflow_o} !== {1'b0, 1'b1, {BW_O{1'b0}}, {BW_CNT{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL single_clear: vld=%b rdy=%b data=%0d cnt=%0d ovf=%b required vld=0 rdy=1 data=0 cnt=0 ovf=0",
               valid_o, ready_o, data_o, beat_cnt_o, overflow_o);
    end
  endtask

  task automatic test_idle_gaps();
    int n = 0;
    for (int b = 0; b < 3; b++) begin
      drive_beat(fill(-32'sd2), b == 2);
      if (b < 2) begin
        data_i = fill(32'd100);
        last_i = 1'b1;
        repeat (2) @(negedge clk);
      end
    end
    while (valid_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (valid_o !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("FAIL idle_gaps: vld=%b queued=%0d required vld=1 with one result", valid_o, sbq.size());
    end else begin
      e = sbq.pop_front();
      if ({data_o, beat_cnt_o, overflow_o} !== {e.data, e.cnt, e.ovf}) begin
        errors++;
        $display("FAIL idle_gaps: data=%0d cnt=%0d ovf=%b required data=%0d cnt=%0d ovf=%b",
                 $signed(data_o), beat_cnt_o, overflow_o, $signed(e.data), e.cnt, e.ovf);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d;
    int n = 0;
    ready_i = 1'b0;
    d = '0;
    d[BW_I-1:0] = BW_I'(5);
    drive_beat(d, 1'b1);
    while (valid_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (valid_o !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("FAIL stall_result: vld=%b queued=%0d required vld=1 with one result", valid_o, sbq.size());
      e.data = 'x; e.cnt = 'x; e.ovf = 1'bx;
    end else begin
      e = sbq.pop_front();
      if ({data_o, beat_cnt_o, overflow_o} !== {e.data, e.cnt, e.ovf}) begin
        errors++;
        $display("FAIL stall_result: data=%0d cnt=%0d ovf=%b required data=%0d cnt=%0d ovf=%b",
                 $signed(data_o), beat_cnt_o, overflow_o, $signed(e.data), e.cnt, e.ovf);
      end
    end
    // Junk offered while stalled must not be taken.
    data_i  = fill(32'd9);
    valid_i = 1'b1;
    last_i  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({valid_o, ready_o, data_o, beat_cnt_o, overflow_o} !== {1'b1, 1'b0, e.data, e.cnt, e.ovf}) begin
        errors++;
        $display("FAIL stall_hold: cycle=%0d vld=%b rdy=%b data=%0d cnt=%0d required vld=1 rdy=0 data=%0d cnt=%0d",
                 k, valid_o, ready_o, $signed(data_o), beat_cnt_o, $signed(e.data), e.cnt);
      end
    end
    ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid_o, ready_o, beat_cnt_o} !== {1'b0, 1'b1, {BW_CNT{1'b0}}}) begin
      errors++;
      $display("FAIL stall_handshake: vld=%b rdy=%b cnt=%0d required vld=0 rdy=1 cnt=0", valid_o, ready_o, beat_cnt_o);
    end
    d[BW_I-1:0] = BW_I'(7);
    drive_beat(d, 1'b1);
    n = 0;
    while (valid_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (valid_o !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("FAIL stall_next: vld=%b queued=%0d required vld=1 with one result", valid_o, sbq.size());
    end else begin
      e = sbq.pop_front();
      if ({data_o, beat_cnt_o, overflow_o} !== {e.data, e.cnt, e.ovf}) begin
        errors++;
        $display("FAIL stall_next: data=%0d cnt=%0d ovf=%b required data=%0d cnt=%0d ovf=%b",
                 $signed(data_o), beat_cnt_o, overflow_o, $signed(e.data), e.cnt, e.ovf);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [BW_I-1:0] v [2];
    int n;
    v[0] = 32'h7FFF_FFFF;
    v[1] = 32'h8000_0000;
    for (int f = 0; f < 2; f++) begin
      drive_beat(fill(v[f]), 1'b0);
      drive_beat(fill(v[f]), 1'b1);
      n = 0;
      while (valid_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (valid_o !== 1'b1 || sbq.size() == 0) begin
        errors++;
        $display("FAIL overflow_%0d: vld=%b queued=%0d required vld=1 with one result", f, valid_o, sbq.size());
      end else begin
        e = sbq.pop_front();
        if ({data_o, beat_cnt_o, overflow_o} !== {e.data, e.cnt, e.ovf}) begin
          errors++;
          $display("FAIL overflow_%0d: data=%h cnt=%0d ovf=%b required data=%h cnt=%0d ovf=%b",
                   f, data_o, beat_cnt_o, overflow_o, e.data, e.cnt, e.ovf);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cnt_sat();
    int n = 0;
    for (int b = 0; b < 18; b++) drive_beat(fill(32'd1), b == 17);
    while (valid_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (valid_o !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("FAIL cnt_sat: vld=%b queued=%0d required vld=1 with one result", valid_o, sbq.size());
    end else begin
      e = sbq.pop_front();
      if ({data_o, beat_cnt_o, overflow_o} !== {e.data, e.cnt, e.ovf}) begin
        errors++;
        $display("FAIL cnt_sat: data=%0d cnt=%0d ovf=%b required data=%0d cnt=%0d ovf=%b",
                 $signed(data_o), beat_cnt_o, overflow_o, $signed(e.data), e.cnt, e.ovf);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] d;
    int vh = 0;
    int n = 0;
    drive_beat(fill(32'd3), 1'b0);
    drive_beat(fill(32'd3), 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({beat_cnt_o, data_o, valid_o, ready_o} !== {{BW_CNT{1'b0}}, {BW_O{1'b0}}, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midframe_async: cnt=%0d data=%0d vld=%b rdy=%b required cnt=0 data=0 vld=0 rdy=1",
               beat_cnt_o, data_o, valid_o, ready_o);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (valid_o !== 1'b0) vh++;
    end
    checks++;
    if (vh != 0) begin
      errors++;
      $display("FAIL midframe_no_out: valid_o high for %0d cycles required 0", vh);
    end
    d = '0;
    d[BW_I-1:0] = BW_I'(1);
    drive_beat(d, 1'b1);
    while (valid_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (valid_o !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("FAIL midframe_next: vld=%b queued=%0d required vld=1 with one result", valid_o, sbq.size());
    end else begin
      e = sbq.pop_front();
      if ({data_o, beat_cnt_o, overflow_o} !== {e.data, e.cnt, e.ovf}) begin
        errors++;
        $display("FAIL midframe_next: data=%0d cnt=%0d ovf=%b required data=%0d cnt=%0d ovf=%b",
                 $signed(data_o), beat_cnt_o, overflow_o, $signed(e.data), e.cnt, e.ovf);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_out();
    int n = 0;
    int vh = 0;
    ready_i = 1'b0;
    drive_beat(fill(32'd4), 1'b1);
    while (valid_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL out_reset_pending: vld=%b required 1", valid_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_o, data_o, beat_cnt_o} !== {1'b0, {BW_O{1'b0}}, {BW_CNT{1'b0}}}) begin
      errors++;
      $display("FAIL out_reset_async: vld=%b data=%0d cnt=%0d required vld=0 data=0 cnt=0", valid_o, data_o, beat_cnt_o);
    end
    if (sbq.size() != 0) e = sbq.pop_front();
    @(negedge clk);
    rst_n   = 1'b1;
    ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (valid_o !== 1'b0) vh++;
    end
    checks++;
    if (vh != 0) begin
      errors++;
      $display("FAIL out_reset_no_out: valid_o high for %0d cycles required 0", vh);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    int nb;
    int n;
    for (int f = 0; f < 6; f++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < VL; i++) begin
          if (f % 2 == 0) d[i*BW_I +: BW_I] = $urandom;
          else            d[i*BW_I +: BW_I] = BW_I'($urandom_range(0, 2000)) - BW_I'(1000);
        end
        drive_beat(d, b == nb - 1);
      end
      n = 0;
      while (valid_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (valid_o !== 1'b1 || sbq.size() == 0) begin
        errors++;
        $display("FAIL b2b_%0d: vld=%b queued=%0d required vld=1 with one result", f, valid_o, sbq.size());
      end else begin
        e = sbq.pop_front();
        if ({data_o, beat_cnt_o, overflow_o} !== {e.data, e.cnt, e.ovf}) begin
          errors++;
          $display("FAIL b2b_%0d: data=%h cnt=%0d ovf=%b required data=%h cnt=%0d ovf=%b",
                   f, data_o, beat_cnt_o, overflow_o, e.data, e.cnt, e.ovf);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_idle_gaps();
    test_backpressure();
    test_overflow();
    test_cnt_sat();
    test_reset_midframe();
    test_reset_in_out();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
